// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between four producers, the arbiter and the consumer.
// Producer side drives in_*, consumer side drives out_ready.
interface mux_rr_arbiter_if #(
   parameter int DATA_W = 64
);
   logic [3:0]        in_valid;
   logic [3:0]        in_last;
   logic [3:0]        in_ready;
   logic [DATA_W-1:0] in_data0;
   logic [DATA_W-1:0] in_data1;
   logic [DATA_W-1:0] in_data2;
   logic [DATA_W-1:0] in_data3;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic [1:0]        out_src;
   logic [1:0]        ctrl;

   modport master (
      output in_valid,
      output in_last,
      output in_data0,
      output in_data1,
      output in_data2,
      output in_data3,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_last,
      input  out_src,
      input  ctrl
   );

   modport slave (
      input  in_valid,
      input  in_last,
      input  in_data0,
      input  in_data1,
      input  in_data2,
      input  in_data3,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_last,
      output out_src,
      output ctrl
   );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter owning the 4-way mux select, with a
// registered output stage that honours consumer backpressure.
module mux_rr_arbiter #(
   parameter int DATA_W    = 64,
   parameter int MAX_BURST = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   mux_rr_arbiter_if.slave bus
);
   localparam int CW =
      (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e            state_q, state_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        sel_q, sel_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ov_q, ov_d;
   logic              ol_q, ol_d;
   logic [DATA_W-1:0] od_q, od_d;
   logic [1:0]        os_q, os_d;

   logic              rdy;
   logic              xfer;
   logic              cut;
   logic              sel_last;
   logic              found;
   logic [1:0]        win;
   logic [1:0]        idx;
   logic [DATA_W-1:0] sel_data;

   always_comb begin
      sel_data = bus.in_data0;
      unique case (sel_q)
         2'd0: sel_data = bus.in_data0;
         2'd1: sel_data = bus.in_data1;
         2'd2: sel_data = bus.in_data2;
         2'd3: sel_data = bus.in_data3;
         default: sel_data = bus.in_data0;
      endcase
   end

   assign sel_last = bus.in_last[sel_q];
   assign rdy  = (state_q == LOCKED) &&
                 (!ov_q || bus.out_ready);
   assign xfer = rdy && bus.in_valid[sel_q];
   assign cut  = sel_last || (cnt_q == CNT_LAST);

   assign bus.in_ready  = rdy ? (4'b0001 << sel_q) : 4'b0000;
   assign bus.ctrl      = sel_q;
   assign bus.out_valid = ov_q;
   assign bus.out_data  = od_q;
   assign bus.out_last  = ol_q;
   assign bus.out_src   = os_q;

   // First valid requester at or after ptr, wrapping mod 4.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      idx   = ptr_q;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && bus.in_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      ov_d    = ov_q;
      ol_d    = ol_q;
      od_d    = od_q;
      os_d    = os_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = LOCKED;
               sel_d   = win;
            end
         end
         LOCKED: begin
            if (xfer && cut) begin
               state_d = IDLE;
               cnt_d   = '0;
               ptr_d   = sel_q + 2'd1;
            end else if (xfer) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (xfer) begin
         ov_d = 1'b1;
         od_d = sel_data;
         os_d = sel_q;
         ol_d = cut;
      end else if (bus.out_ready) begin
         ov_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         ov_q    <= 1'b0;
         ol_q    <= 1'b0;
         od_q    <= '0;
         os_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         ov_q    <= ov_d;
         ol_q    <= ol_d;
         od_q    <= od_d;
         os_q    <= os_d;
      end
   end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural model and a scoreboard.
module tb_mux_rr_arbiter;
   localparam int DW = 64;
   localparam int MB = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux_rr_arbiter_if #(.DATA_W(DW)) bus ();

   mux_rr_arbiter #(
      .DATA_W(DW),
      .MAX_BURST(MB)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct {
      logic [3:0]  ir;
      logic [1:0]  ctrl;
      logic        ov;
      logic [63:0] od;
      logic        ol;
      logic [1:0]  os;
   } snap_t;

   int n_chk = 0;
   int n_err = 0;

   logic [64:0] pq[4][$];
   logic [63:0] sb[4][$];
   snap_t       hist[$];

   bit          m_lock;
   int          m_sel, m_ptr, m_cnt, m_os;
   bit          m_ov, m_ol;
   logic [63:0] m_od;

   logic [3:0]  vld, lst;
   logic [63:0] dat[4];
   logic        rdy;
   int          rdy_mode;
   bit          gate;

   task automatic chk(string tag, logic [63:0] got,
                      logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic push(int r, logic [63:0] d, bit l);
      pq[r].push_back({l, d});
      sb[r].push_back(d);
   endtask

   task automatic burst(int r, int n, logic [63:0] base);
      for (int k = 0; k < n; k++)
         push(r, base + 64'(k), k == n - 1);
   endtask

   task automatic model_clear();
      m_lock = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
      m_ov = 0; m_ol = 0; m_od = '0; m_os = 0;
      for (int r = 0; r < 4; r++) begin
         pq[r].delete();
         sb[r].delete();
      end
      hist.delete();
      vld = '0; lst = '0; rdy = 1'b1;
      for (int r = 0; r < 4; r++) dat[r] = '0;
   endtask

   task automatic drive();
      bus.in_valid  = vld;
      bus.in_last   = lst;
      bus.in_data0  = dat[0];
      bus.in_data1  = dat[1];
      bus.in_data2  = dat[2];
      bus.in_data3  = dat[3];
      bus.out_ready = rdy;
   endtask

   task automatic check_reset_vals(string tag);
      chk({tag, "_ov"}, 64'(bus.out_valid), 0);
      chk({tag, "_od"}, bus.out_data, 0);
      chk({tag, "_ol"}, 64'(bus.out_last), 0);
      chk({tag, "_os"}, 64'(bus.out_src), 0);
      chk({tag, "_ctrl"}, 64'(bus.ctrl), 0);
      chk({tag, "_ir"}, 64'(bus.in_ready), 0);
   endtask

   task automatic check();
      logic [3:0] e_ir;
      int s;
      e_ir = (m_lock && (!m_ov || rdy)) ?
             4'(1 << m_sel) : 4'b0;
      chk("in_ready", 64'(bus.in_ready), 64'(e_ir));
      chk("ctrl", 64'(bus.ctrl), 64'(m_sel));
      chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
      chk("out_data", bus.out_data, m_od);
      chk("out_last", 64'(bus.out_last), 64'(m_ol));
      chk("out_src", 64'(bus.out_src), 64'(m_os));
      if (bus.out_valid && rdy) begin
         s = int'(bus.out_src);
         if (sb[s].size() == 0)
            chk("sb_empty", 1, 0);
         else
            chk("sb_order", bus.out_data, sb[s].pop_front());
      end
      hist.push_back('{bus.in_ready, bus.ctrl, bus.out_valid,
                       bus.out_data, bus.out_last, bus.out_src});
   endtask

   task automatic step();
      bit ready;
      bit e;
      int r;
      ready = m_lock && (!m_ov || rdy);
      if (!m_lock) begin
         for (int k = 0; k < 4; k++) begin
            r = (m_ptr + k) % 4;
            if (vld[r]) begin
               m_lock = 1;
               m_sel  = r;
               break;
            end
         end
         if (rdy) m_ov = 0;
      end else if (ready && vld[m_sel]) begin
         e = lst[m_sel] || (m_cnt == MB - 1);
         m_od = dat[m_sel];
         m_os = m_sel;
         m_ov = 1;
         m_ol = e;
         void'(pq[m_sel].pop_front());
         if (e) begin
            m_lock = 0;
            m_cnt  = 0;
            m_ptr  = (m_sel + 1) % 4;
         end else begin
            m_cnt++;
         end
      end else if (rdy) begin
         m_ov = 0;
      end
   endtask

   task automatic cycle();
      rdy = (rdy_mode == 0) ? 1'b1 :
            (rdy_mode == 2) ? 1'b0 :
            ($urandom_range(0, 2) != 0);
      for (int r = 0; r < 4; r++) begin
         if (pq[r].size() != 0) begin
            {lst[r], dat[r]} = pq[r][0];
            vld[r] = gate ? ($urandom_range(0, 3) != 0) : 1'b1;
         end else begin
            vld[r] = 1'b0;
            lst[r] = 1'($urandom);
            dat[r] = {$urandom, $urandom};
         end
      end
      drive();
      @(negedge clk);
      check();
      step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      model_clear();
      rdy_mode = 0;
      gate = 0;
      drive();
      #1;
      check_reset_vals("rst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic run(int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int pend;
      // 3-beat burst on requester 0, then ptr=1 picks requester 1
      reset_dut();
      burst(0, 3, 64'd10);
      run(6);
      chk("t1_ir1", 64'(hist[1].ir), 64'h1);
      chk("t1_ctrl1", 64'(hist[1].ctrl), 0);
      chk("t1_d2", hist[2].od, 10);
      chk("t1_l2", 64'(hist[2].ol), 0);
      chk("t1_d3", hist[3].od, 11);
      chk("t1_d4", hist[4].od, 12);
      chk("t1_l4", 64'(hist[4].ol), 1);
      chk("t1_v5", 64'(hist[5].ov), 0);
      push(0, 64'd20, 1);
      push(1, 64'd21, 1);
      run(6);
      chk("t1_ptr1", 64'(hist[7].ir), 64'h2);

      // All four valid, single-beat bursts: grants rotate 0,1,2,3,0
      reset_dut();
      for (int r = 0; r < 4; r++) begin
         push(r, 64'(100 + r), 1);
         push(r, 64'(200 + r), 1);
      end
      run(18);
      for (int k = 0; k < 5; k++) begin
         chk("t2_v", 64'(hist[2 + 2 * k].ov), 1);
         chk("t2_src", 64'(hist[2 + 2 * k].os), 64'(k % 4));
      end
      chk("t2_bubble", 64'(hist[3].ov), 0);

      // Requester 2 stalled 3 cycles after its first beat
      reset_dut();
      burst(2, 4, 64'd300);
      run(2);
      rdy_mode = 2;
      run(3);
      rdy_mode = 0;
      run(6);
      for (int k = 2; k <= 4; k++) begin
         chk("t3_hold", hist[k].od, 300);
         chk("t3_ir0", 64'(hist[k].ir), 0);
      end
      chk("t3_resume", 64'(hist[5].ir), 64'h4);
      chk("t3_d6", hist[6].od, 301);
      chk("t3_d8", hist[8].od, 303);
      chk("t3_l8", 64'(hist[8].ol), 1);

      // Beat-limit cut on requester 1, requester 3 gets a turn
      reset_dut();
      burst(1, 20, 64'd400);
      push(3, 64'd900, 1);
      run(26);
      chk("t4_l16", 64'(hist[16].ol), 0);
      chk("t4_d17", hist[17].od, 415);
      chk("t4_l17", 64'(hist[17].ol), 1);
      chk("t4_s19", 64'(hist[19].os), 3);
      chk("t4_s21", 64'(hist[21].os), 1);
      chk("t4_d21", hist[21].od, 416);

      // Reset in the middle of a 4-beat burst with a held beat
      reset_dut();
      push(1, 64'd500, 1);
      burst(2, 4, 64'd510);
      run(5);
      chk("t5_pre_ov", 64'(bus.out_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("t5");
      model_clear();
      drive();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push(1, 64'd520, 1);
      push(3, 64'd530, 1);
      run(6);
      chk("t5_grant", 64'(hist[1].ir), 64'h2);

      // Requester 3 wins, ptr wraps, requester 0 beats 2
      reset_dut();
      push(3, 64'd600, 1);
      run(1);
      push(0, 64'd610, 1);
      push(2, 64'd620, 1);
      run(8);
      chk("t6_s2", 64'(hist[2].os), 3);
      chk("t6_ir3", 64'(hist[3].ir), 64'h1);
      chk("t6_ctrl3", 64'(hist[3].ctrl), 0);

      // Random traffic with gated valids and random backpressure
      reset_dut();
      rdy_mode = 1;
      gate = 1;
      for (int c = 0; c < 3000; c++) begin
         for (int r = 0; r < 4; r++)
            if (pq[r].size() < 3 && $urandom_range(0, 9) == 0)
               burst(r, $urandom_range(1, 20),
                     {$urandom, $urandom});
         cycle();
      end
      rdy_mode = 0;
      gate = 0;
      for (int c = 0; c < 600; c++) begin
         pend = 0;
         for (int r = 0; r < 4; r++)
            pend += pq[r].size() + sb[r].size();
         if (pend == 0) break;
         cycle();
      end
      pend = 0;
      for (int r = 0; r < 4; r++)
         pend += pq[r].size() + sb[r].size();
      chk("drain", 64'(pend), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
